// File: rtl/over_threshold_monitor_if.sv
// Bus between the threshold comparator path and the persistence monitor.
// master drives the control/sample side, slave is the monitor itself.
interface over_threshold_monitor_if #(
    parameter int unsigned CNT_W = 8
);
    logic             enable;
    logic             sample_en;
    logic             cmp_in;
    logic             ack;
    logic             count_clr;
    logic             alarm;
    logic             alarm_event;
    logic [CNT_W-1:0] event_count;
    logic [1:0]       state;

    modport master (
        output enable,
        output sample_en,
        output cmp_in,
        output ack,
        output count_clr,
        input  alarm,
        input  alarm_event,
        input  event_count,
        input  state
    );

    modport slave (
        input  enable,
        input  sample_en,
        input  cmp_in,
        input  ack,
        input  count_clr,
        output alarm,
        output alarm_event,
        output event_count,
        output state
    );
endinterface

// File: rtl/over_threshold_monitor.sv
// Persistence filter on the registered comparator output: alarm is entered
// after ON_COUNT consecutive high samples and left after OFF_COUNT consecutive
// low samples. Tracks a sticky entry flag and a saturating entry counter.
module over_threshold_monitor #(
    parameter int unsigned ON_COUNT  = 4,
    parameter int unsigned OFF_COUNT = 4,
    parameter int unsigned RUN_W     = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    over_threshold_monitor_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ALARM     = 2'd2,
        RELEASING = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               alarm_q, alarm_d;
    logic               event_q, event_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               sample_c;
    logic               entry_c;
    logic [RUN_W-1:0]   run_inc_c;

    assign sample_c  = bus.enable & bus.sample_en;
    assign run_inc_c = run_q + RUN_W'(1);

    // State register and all output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            alarm_q <= 1'b0;
            event_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            event_q <= event_d;
            count_q <= count_d;
        end
    end

    // Next-state: run-length persistence FSM, only advanced on sample ticks
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (!bus.enable) begin
            state_d = IDLE;
            run_d   = '0;
        end else if (sample_c) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.cmp_in) begin
                        if (ON_COUNT == 1) begin
                            state_d = ALARM;
                            run_d   = '0;
                        end else begin
                            state_d = ARMING;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (bus.cmp_in) begin
                        if (run_inc_c == RUN_W'(ON_COUNT)) begin
                            state_d = ALARM;
                            run_d   = '0;
                        end else begin
                            run_d   = run_inc_c;
                        end
                    end else begin
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
                ALARM: begin
                    if (!bus.cmp_in) begin
                        if (OFF_COUNT == 1) begin
                            state_d = IDLE;
                            run_d   = '0;
                        end else begin
                            state_d = RELEASING;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                RELEASING: begin
                    if (!bus.cmp_in) begin
                        if (run_inc_c == RUN_W'(OFF_COUNT)) begin
                            state_d = IDLE;
                            run_d   = '0;
                        end else begin
                            run_d   = run_inc_c;
                        end
                    end else begin
                        state_d = ALARM;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Entry detection; RELEASING->ALARM is a bounce, not a new event
    always_comb begin
        entry_c = (state_d == ALARM) &&
                  ((state_q == IDLE) || (state_q == ARMING));
    end

    // Output next-values: alarm level, sticky flag (set wins), counter (clear wins)
    always_comb begin
        alarm_d = (state_d == ALARM) || (state_d == RELEASING);
        event_d = event_q;
        count_d = count_q;
        if (entry_c) begin
            event_d = 1'b1;
        end else if (bus.ack) begin
            event_d = 1'b0;
        end
        if (bus.count_clr) begin
            count_d = '0;
        end else if (entry_c && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    assign bus.alarm       = alarm_q;
    assign bus.alarm_event = event_q;
    assign bus.event_count = count_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_over_threshold_monitor.sv
// Scoreboard bench: stimulus pushes expected outputs, a negedge monitor pops
// and compares. Unit 0 uses the default parameters, unit 1 has CNT_W=2.
module tb_over_threshold_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    over_threshold_monitor_if #(.CNT_W(8)) b0 ();
    over_threshold_monitor_if #(.CNT_W(2)) b1 ();

    over_threshold_monitor #(.ON_COUNT(4), .OFF_COUNT(4), .RUN_W(4), .CNT_W(8)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    over_threshold_monitor #(.ON_COUNT(4), .OFF_COUNT(4), .RUN_W(4), .CNT_W(2)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    typedef struct {
        string name;
        int    d;
        bit    al;
        bit    ev;
        int    cnt;
        int    st;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor: compare every pending expectation away from the active edge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            bit   a_al, a_ev;
            int   a_cnt, a_st;
            e = q.pop_front();
            if (e.d == 0) begin
                a_al = b0.alarm; a_ev = b0.alarm_event;
                a_cnt = int'(b0.event_count); a_st = int'(b0.state);
            end else begin
                a_al = b1.alarm; a_ev = b1.alarm_event;
                a_cnt = int'(b1.event_count); a_st = int'(b1.state);
            end
            checks++;
            if (a_al !== e.al || a_ev !== e.ev || a_cnt != e.cnt || a_st != e.st) begin
                failures++;
                $display("FAIL %s: got alarm=%0b event=%0b count=%0d state=%0d, want alarm=%0b event=%0b count=%0d state=%0d",
                         e.name, a_al, a_ev, a_cnt, a_st, e.al, e.ev, e.cnt, e.st);
            end
        end
    end

    task automatic drv(input int d, input bit en, input bit se, input bit cmp,
                       input bit ak, input bit clr);
        if (d == 0) begin
            b0.enable = en; b0.sample_en = se; b0.cmp_in = cmp; b0.ack = ak; b0.count_clr = clr;
        end else begin
            b1.enable = en; b1.sample_en = se; b1.cmp_in = cmp; b1.ack = ak; b1.count_clr = clr;
        end
    endtask

    // One clock with the given inputs; pulses fall back low afterwards
    task automatic tick(input int d, input bit en, input bit se, input bit cmp,
                        input bit ak, input bit clr);
        @(negedge clk);
        drv(d, en, se, cmp, ak, clr);
        @(posedge clk);
        #1;
        drv(d, en, 1'b0, cmp, 1'b0, 1'b0);
    endtask

    task automatic samples(input int d, input bit cmp, input int n);
        for (int i = 0; i < n; i++) tick(d, 1'b1, 1'b1, cmp, 1'b0, 1'b0);
    endtask

    task automatic expect_o(input string name, input int d, input bit al, input bit ev,
                            input int cnt, input int st);
        exp_t e;
        e.name = name; e.d = d; e.al = al; e.ev = ev; e.cnt = cnt; e.st = st;
        q.push_back(e);
    endtask

    initial begin
        drv(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        expect_o("reset_state", 0, 0, 0, 0, 0);
        expect_o("reset_state_small", 1, 0, 0, 0, 0);
        #1 rst = 1'b0;

        // Entry: high samples spaced 3 clocks apart
        for (int k = 1; k <= 4; k++) begin
            tick(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            if (k == 1) expect_o("entry_tick1", 0, 0, 0, 0, 1);
            if (k == 3) expect_o("entry_tick3", 0, 0, 0, 0, 1);
            if (k == 4) expect_o("entry_tick4", 0, 1, 1, 1, 2);
            if (k < 4) begin
                tick(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                tick(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                if (k == 3) expect_o("entry_gap_hold", 0, 0, 0, 0, 1);
            end
        end

        // Async reset in ALARM, seen before the next rising edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1 expect_o("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Glitch: 3 high then 1 low never alarms
        samples(0, 1'b1, 3);
        expect_o("glitch_3high", 0, 0, 0, 0, 1);
        samples(0, 1'b0, 1);
        expect_o("glitch_low", 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1'b1, 1'b0, i[0], 1'b0, 1'b0);
        expect_o("idle_no_sample", 0, 0, 0, 0, 0);

        // Run length preserved across unsampled toggles
        samples(0, 1'b1, 2);
        for (int i = 0; i < 4; i++) tick(0, 1'b1, 1'b0, i[0], 1'b0, 1'b0);
        expect_o("arming_hold", 0, 0, 0, 0, 1);
        samples(0, 1'b1, 2);
        expect_o("arming_resume_entry", 0, 1, 1, 1, 2);

        // Release: 3 low, 1 high, 4 low
        samples(0, 1'b0, 3);
        expect_o("release_3low", 0, 1, 1, 1, 3);
        samples(0, 1'b1, 1);
        expect_o("release_bounce", 0, 1, 1, 1, 2);
        samples(0, 1'b0, 3);
        expect_o("release_7th", 0, 1, 1, 1, 3);
        samples(0, 1'b0, 1);
        expect_o("release_8th", 0, 0, 1, 1, 0);

        // Sticky flag and priorities
        tick(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_o("ack_alone", 0, 0, 0, 1, 0);
        samples(0, 1'b1, 3);
        tick(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_o("ack_with_entry", 0, 1, 1, 2, 2);
        samples(0, 1'b0, 4);
        tick(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_o("ack_after_release", 0, 0, 0, 2, 0);
        samples(0, 1'b1, 3);
        tick(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_o("clr_with_entry", 0, 1, 1, 0, 2);

        // Bounce back from RELEASING records no event
        tick(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_o("ack_in_alarm", 0, 1, 0, 0, 2);
        samples(0, 1'b0, 1);
        samples(0, 1'b1, 1);
        expect_o("bounce_no_event", 0, 1, 0, 0, 2);

        // enable low forces IDLE, flag and counter kept
        tick(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        samples(0, 1'b0, 1);
        samples(0, 1'b1, 1);
        tick(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_o("enable_low", 0, 0, 0, 0, 0);
        tick(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Saturation on the 2-bit counter unit
        for (int k = 1; k <= 5; k++) begin
            samples(1, 1'b1, 4);
            expect_o($sformatf("sat_entry%0d", k), 1, 1, 1, (k > 3) ? 3 : k, 2);
            if (k < 5) begin
                tick(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                tick(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end
        tick(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_o("sat_enable_low", 1, 0, 1, 3, 0);

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
